// File: rtl/sa_adc_pkg.sv
// sa_adc_pkg: shared FSM encoding and default timing for the SAR ADC sequencer.
package sa_adc_pkg;
    typedef enum logic [2:0] {IDLE, SAMPLE, SHIFT, LATCH, SETTLE, DECIDE, DONE} state_t;
    localparam int DEF_SAMPLE_CYCLES = 32;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_SCLK_HALF = 2;
    localparam int TMR_W = 16;
endpackage

// File: rtl/sa_adc_if.sv
// sa_adc_if: analog front-end signals between the SAR sequencer and the DAC/comparator side.
interface sa_adc_if;
    logic sh;
    logic ser;
    logic sclk;
    logic lclk;
    logic comp;
    logic [13:0] data;
    logic rdy;
    modport master (output sh, ser, sclk, lclk, data, rdy, input comp);
    modport slave (input sh, ser, sclk, lclk, data, rdy, output comp);
endinterface

// File: rtl/pll.sv
// pll: iCE40 core clock source, 12 MHz reference to 36 MHz (DIVR=0, DIVF=47, DIVQ=4).
// The SB_PLL40_CORE is bound here by the iCE40 flow; elsewhere the reference passes straight through.
module pll (
    input  logic clock_in,
    output logic clock_out
);
    assign clock_out = clock_in;
endmodule

// File: rtl/sa_adc_ctrl.sv
// sa_adc_ctrl: 14-bit successive-approximation sequencer feeding a serial 16-bit DAC.
module sa_adc_ctrl
    import sa_adc_pkg::*;
#(
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SCLK_HALF = DEF_SCLK_HALF
) (
    input logic clk,
    input logic rst_n,
    sa_adc_if.master bus
);
    state_t state, state_d;
    logic [TMR_W-1:0] tmr, tmr_d;
    logic [3:0] idx, idx_d, cnt, cnt_d;
    logic [13:0] trial, trial_d, data, data_d, decided, nxt;
    logic [15:0] word, word_d;
    logic sh, sh_d, sclk, sclk_d, lclk, lclk_d, rdy, rdy_d;
    logic [1:0] comp_q;
    always_comb begin
        state_d = state;
        tmr_d = tmr + 1'b1;
        idx_d = idx;
        cnt_d = cnt;
        trial_d = trial;
        data_d = data;
        word_d = word;
        sh_d = sh;
        sclk_d = sclk;
        lclk_d = lclk;
        rdy_d = 1'b0;
        decided = trial;
        decided[idx] = comp_q[1];
        nxt = decided | (14'(1) << (idx - 4'd1));
        case (state)
            IDLE: begin
                state_d = SAMPLE;
                tmr_d = '0;
                sh_d = 1'b1;
                trial_d = '0;
            end
            SAMPLE: if (tmr == TMR_W'(SAMPLE_CYCLES - 1)) begin
                state_d = SHIFT;
                tmr_d = '0;
                sh_d = 1'b0;
                idx_d = 4'd13;
                cnt_d = '0;
                trial_d = 14'h2000;
                word_d = {2'b00, 14'h2000};
            end
            SHIFT: begin
                if (tmr == TMR_W'(SCLK_HALF - 1)) sclk_d = 1'b1;
                // bit boundary: SClk falls and the next bit is presented on the same edge
                if (tmr == TMR_W'(2 * SCLK_HALF - 1)) begin
                    tmr_d = '0;
                    sclk_d = 1'b0;
                    state_d = cnt == 4'd15 ? LATCH : SHIFT;
                    lclk_d = cnt == 4'd15;
                    cnt_d = cnt == 4'd15 ? cnt : cnt + 4'd1;
                    word_d = cnt == 4'd15 ? word : word >> 1;
                end
            end
            LATCH: if (tmr == TMR_W'(SCLK_HALF - 1)) begin
                state_d = SETTLE;
                tmr_d = '0;
                lclk_d = 1'b0;
            end
            SETTLE: if (tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
                state_d = DECIDE;
                tmr_d = '0;
            end
            DECIDE: begin
                tmr_d = '0;
                cnt_d = '0;
                state_d = idx == 4'd0 ? DONE : SHIFT;
                idx_d = idx == 4'd0 ? idx : idx - 4'd1;
                trial_d = idx == 4'd0 ? decided : nxt;
                word_d = {2'b00, nxt};
            end
            DONE: begin
                state_d = SAMPLE;
                tmr_d = '0;
                sh_d = 1'b1;
                data_d = trial;
                rdy_d = 1'b1;
                trial_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tmr <= '0;
            idx <= '0;
            cnt <= '0;
            trial <= '0;
            data <= '0;
            word <= '0;
            sh <= 1'b1;
            sclk <= 1'b0;
            lclk <= 1'b0;
            rdy <= 1'b0;
            comp_q <= '0;
        end else begin
            state <= state_d;
            tmr <= tmr_d;
            idx <= idx_d;
            cnt <= cnt_d;
            trial <= trial_d;
            data <= data_d;
            word <= word_d;
            sh <= sh_d;
            sclk <= sclk_d;
            lclk <= lclk_d;
            rdy <= rdy_d;
            comp_q <= {comp_q[0], bus.comp};
        end
    end
    assign bus.sh = sh;
    assign bus.ser = word[0];
    assign bus.sclk = sclk;
    assign bus.lclk = lclk;
    assign bus.data = data;
    assign bus.rdy = rdy;
endmodule

// File: rtl/main.sv
// main: continuous 14-bit SAR ADC controller on the PLL clock.
module main
    import sa_adc_pkg::*;
#(
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SCLK_HALF = DEF_SCLK_HALF
) (
    input  logic        pin_clk_i,
    input  logic        reset_ni,
    output logic        SA_ADC_SH_o,
    output logic        SA_ADC_Ser_o,
    output logic        SA_ADC_SClk_o,
    output logic        SA_ADC_LClk_o,
    input  logic        SA_ADC_Comp_i,
    output logic [13:0] SA_ADC_data_o,
    output logic        SA_ADC_data_rdy_o
);
    logic clk;
    logic [1:0] rst_sync;
    sa_adc_if adc ();
    pll pll_36mh (.clock_in(pin_clk_i), .clock_out(clk));
    // asserts immediately, releases two core clocks later
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) rst_sync <= '0;
        else rst_sync <= {rst_sync[0], 1'b1};
    end
    sa_adc_ctrl #(
        .SAMPLE_CYCLES(SAMPLE_CYCLES),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .SCLK_HALF(SCLK_HALF)
    ) u_ctrl (
        .clk(clk),
        .rst_n(rst_sync[1]),
        .bus(adc.master)
    );
    assign adc.comp = SA_ADC_Comp_i;
    assign SA_ADC_SH_o = adc.sh;
    assign SA_ADC_Ser_o = adc.ser;
    assign SA_ADC_SClk_o = adc.sclk;
    assign SA_ADC_LClk_o = adc.lclk;
    assign SA_ADC_data_o = adc.data;
    assign SA_ADC_data_rdy_o = adc.rdy;
endmodule

// File: tb/tb_main.sv
// tb_main: drives main against a modelled serial DAC + comparator and scoreboards every conversion.
module tb_main;
    import sa_adc_pkg::*;
    localparam int S = DEF_SAMPLE_CYCLES;
    localparam int SET = DEF_SETTLE_CYCLES;
    localparam int H = DEF_SCLK_HALF;
    localparam int PERIOD = S + 14 * (32 * H + H + SET + 1) + 1;
    logic clk = 1'b0;
    logic reset_ni = 1'b1;
    logic [15:0] adc_val = '0;
    logic [15:0] sr = '0;
    logic [15:0] lat = '0;
    logic [13:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    sa_adc_if bus ();
    main #(.SAMPLE_CYCLES(S), .SETTLE_CYCLES(SET), .SCLK_HALF(H)) dut (
        .pin_clk_i(clk),
        .reset_ni(reset_ni),
        .SA_ADC_SH_o(bus.sh),
        .SA_ADC_Ser_o(bus.ser),
        .SA_ADC_SClk_o(bus.sclk),
        .SA_ADC_LClk_o(bus.lclk),
        .SA_ADC_Comp_i(bus.comp),
        .SA_ADC_data_o(bus.data),
        .SA_ADC_data_rdy_o(bus.rdy)
    );
    always #10 clk = ~clk;
    // external DAC: LSB-first shift register, latched on LClk, compared against the input level
    always @(posedge bus.sclk) sr <= {bus.ser, sr[15:1]};
    always @(posedge bus.lclk) lat <= sr;
    assign bus.comp = lat <= adc_val;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // SAR converges on the largest 14-bit code whose DAC word is <= the input
    function automatic logic [13:0] sar(input logic [15:0] v);
        return v > 16'h3FFF ? 14'h3FFF : v[13:0];
    endfunction
    task automatic wait_rdy();
        bit seen = 0;
        for (int i = 0; i < 2 * PERIOD && !seen; i++) begin
            @(negedge clk);
            seen = bus.rdy;
        end
        if (!seen) check("rdy_timeout", 0, 1);
    endtask
    task automatic check_reset_outputs(input string tag);
        check({tag, "_sh"}, bus.sh, 1);
        check({tag, "_ser"}, bus.ser, 0);
        check({tag, "_sclk"}, bus.sclk, 0);
        check({tag, "_lclk"}, bus.lclk, 0);
        check({tag, "_data"}, bus.data, 0);
        check({tag, "_rdy"}, bus.rdy, 0);
    endtask
    logic p_sclk = 0, p_lclk = 0, p_ser = 0, p_rdy = 0;
    int sclk_n = 0, rdy_len = 0, cyc = 0, last = 0;
    bit have_prev = 0;
    always @(negedge clk) begin
        cyc++;
        if (!reset_ni) begin
            sclk_n = 0;
            rdy_len = 0;
            have_prev = 0;
        end else begin
            if (bus.sclk && !p_sclk) begin
                sclk_n++;
                check("sh_low_in_trial", bus.sh, 0);
            end
            if (bus.sclk && p_sclk) check("ser_stable_sclk_hi", bus.ser, p_ser);
            if (bus.lclk && !p_lclk) begin
                check("sclk_edges_per_latch", sclk_n, 16);
                sclk_n = 0;
            end
            if (bus.rdy) rdy_len++;
            if (bus.rdy && !p_rdy) begin
                if (exp_q.size() == 0) check("rdy_unexpected", 1, 0);
                else check("data", bus.data, exp_q.pop_front());
                if (have_prev) check("period", cyc - last, PERIOD);
                last = cyc;
                have_prev = 1;
            end
            if (!bus.rdy && p_rdy) begin
                check("rdy_width", rdy_len, 1);
                rdy_len = 0;
            end
        end
        p_sclk = bus.sclk;
        p_lclk = bus.lclk;
        p_ser = bus.ser;
        p_rdy = bus.rdy;
    end
    initial begin
        logic [15:0] vals[7] = '{16'h2FFF, 16'h2FFF, 16'h2FFF, 16'h0000, 16'hFFFF, 16'h1234, 16'h0ABC};
        bit hi = 0;
        #5 reset_ni = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset_ni = 1'b1;
        foreach (vals[i]) begin
            adc_val = vals[i];
            exp_q.push_back(sar(vals[i]));
            wait_rdy();
        end
        adc_val = 16'h2FFF;
        exp_q.push_back(sar(adc_val));
        for (int i = 0; i < PERIOD && !hi; i++) begin
            @(negedge clk);
            hi = bus.sclk;
        end
        check("reach_shift", hi, 1);
        #2 reset_ni = 1'b0;
        #1 check_reset_outputs("async");
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_reset_outputs("held");
        reset_ni = 1'b1;
        adc_val = 16'h0F0F;
        exp_q.push_back(sar(adc_val));
        wait_rdy();
        adc_val = 16'h3000;
        exp_q.push_back(sar(adc_val));
        wait_rdy();
        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 Parameter SAMPLE_CYCLES, default 32: system clocks for which SA_ADC_SH_o is held high (track phase) before each conversion.
REQ-002 Parameter SETTLE_CYCLES, default 16: system clocks waited after each DAC latch before the comparator is sampled.
REQ-003 Parameter SCLK_HALF, default 2: system clocks per SA_ADC_SClk_o half-period; also the SA_ADC_LClk_o high time.
REQ-004 pin_clk_i  input  1: board reference clock; feeds the PLL only.
REQ-005 reset_ni  input  1: one clock; reset is asynchronous and active-low.
REQ-006 SA_ADC_SH_o  output  1: sample/hold control; 1 = track, 0 = hold.
REQ-007 SA_ADC_Ser_o  output  1: serial data to the external 16-bit DAC shift register.
REQ-008 SA_ADC_SClk_o  output  1: shift clock; the external register shifts on its rising edge.
REQ-009 SA_ADC_LClk_o  output  1: latch clock; the external register copies the shift stage to the DAC on its rising edge.
REQ-010 SA_ADC_Comp_i  input  1: comparator output; 1 = analog input >= DAC voltage; asynchronous.
REQ-011 SA_ADC_data_o  output  14: last completed conversion result.
REQ-012 SA_ADC_data_rdy_o  output  1: one-cycle pulse when SA_ADC_data_o is updated.

Function
REQ-013 All logic SHALL run on the PLL output clock (clock_out); pin_clk_i drives nothing else.
REQ-014 The block SHALL convert continuously in order: SAMPLE, then 14 trials from bit 13 down to bit 0, then DONE, then SAMPLE again.
REQ-015 SAMPLE: SH=1 for SAMPLE_CYCLES clocks, and the trial register is cleared; SH=0 from the first trial until DONE.
REQ-016 Each trial SHALL set the current bit in the trial register and form the DAC word {2'b00, trial[13:0]}.
REQ-017 SHIFT: 16 bits sent LSB first (word bit 0 first, bit 15 last). Per bit, Ser is stable for SCLK_HALF clocks with SClk=0, then SClk=1 for SCLK_HALF clocks. Ser changes only while SClk=0.
REQ-018 LATCH: after the 16th bit, SClk=0 and LClk=1 for SCLK_HALF clocks, then LClk=0.
REQ-019 SETTLE: wait SETTLE_CYCLES clocks. Then read the synchronized comparator: 1 keeps the bit, 0 clears it.
REQ-020 SA_ADC_Comp_i SHALL pass through a 2-flop synchronizer before use; SETTLE_CYCLES >= 4 is required.
REQ-021 DONE: SA_ADC_data_o <= trial[13:0] and SA_ADC_data_rdy_o = 1 for exactly one clock; data_o holds until the next DONE.
REQ-022 States: IDLE(reset), SAMPLE, SHIFT, LATCH, SETTLE, DECIDE, DONE. Bit index 13..0 and shift count 0..15 SHALL never wrap mid-conversion.
REQ-023 Conversion period SHALL be SAMPLE_CYCLES + 14*(32*SCLK_HALF + SCLK_HALF + SETTLE_CYCLES + 1) + small constant (<=4) clocks.
REQ-024 A full-scale input (comparator always 1) SHALL give 14'h3FFF; comparator always 0 SHALL give 14'h0000.

Reset
REQ-025 Assertion SHALL be asynchronous. Deassertion SHALL be synchronized to clock_out with 2 flops.
REQ-026 In reset: SH=1, Ser=0, SClk=0, LClk=0, data_o=0, data_rdy_o=0, FSM=IDLE, trial register=0.
REQ-027 After release, the FSM SHALL enter SAMPLE on the next clock. Reset mid-conversion SHALL abort it without a data_rdy pulse.

Structure
REQ-028 FSM state encoding and default timing constants SHALL live in a shared package, sa_adc_pkg.
REQ-029 PLL SHALL be a separate sub-module, pll (iCE40 PLL wrapper, 12 MHz to 36 MHz), instantiated as pll_36mh, with output port clock_out (simulation may force it).
REQ-030 The SAR FSM/serializer MAY be a single sub-module, sa_adc_ctrl. Total RTL SHALL be 120-400 lines.

Verification
REQ-031 The bench SHALL model a 16-bit LSB-first shift register plus latch, with Comp = (latched word <= ADC_VAL).
REQ-032 ADC_VAL=16'h2FFF, 50 MHz clock, 100 us run: data_o = 14'h2FFF at every data_rdy pulse, at least 3 pulses.
REQ-033 ADC_VAL=16'h0000 -> data_o=14'h0000; ADC_VAL=16'hFFFF -> data_o=14'h3FFF.
REQ-034 The shift protocol SHALL be checked: exactly 16 SClk rising edges between LClk pulses, Ser never toggling while SClk=1, and SH=0 throughout the trials.
REQ-035 Reset asserted mid-shift: outputs SHALL reach REQ-026 values asynchronously, and after release the first data_rdy SHALL carry a correct full result.
REQ-036 data_rdy_o width SHALL be exactly 1 clock, and the spacing between pulses SHALL match REQ-023.
